// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO bank: output/direction registers with atomic set/clear, synchronised
// inputs, and per-pin edge interrupts with write-1-to-clear status.
module wb_gpio_irq #(
  parameter int NGPIO       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             wb_cyc,
  input  logic             wb_stb,
  input  logic             wb_we,
  input  logic [3:0]       wb_sel,
  input  logic [7:0]       wb_adr,
  input  logic [31:0]      wb_dat,
  output logic [31:0]      wb_rdt,
  output logic             wb_ack,
  input  logic [NGPIO-1:0] gpi,
  output logic [NGPIO-1:0] gpo,
  output logic [NGPIO-1:0] gpoe,
  output logic             irq
);

  localparam logic [2:0] A_OUT  = 3'd0, A_SET = 3'd1, A_CLR  = 3'd2, A_DIR  = 3'd3,
                         A_IN   = 3'd4, A_EN  = 3'd5, A_STAT = 3'd6, A_EDGE = 3'd7;

  logic [NGPIO-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
  logic [NGPIO-1:0] stat_q, stat_d, edg_q, edg_d, prev_q, prev_d;
  logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_q, sync_d;
  logic             ack_q, ack_d, irq_q, irq_d;

  logic [2:0]       widx;
  logic             wr;
  logic [31:0]      m32;
  logic [NGPIO-1:0] bm, wd, s, ev, rd_n;
  logic             unused_bits;

  assign widx = wb_adr[4:2];
  // Commit only on the first cycle of an access so a write lands exactly once.
  assign wr   = wb_cyc & wb_stb & wb_we & ~ack_q;
  assign m32  = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
  assign bm   = m32[NGPIO-1:0];
  assign wd   = wb_dat[NGPIO-1:0] & bm;
  assign s    = sync_q[SYNC_STAGES-1];
  assign ev   = (edg_q & s & ~prev_q) | (~edg_q & ~s & prev_q);
  assign unused_bits = ^{wb_adr[7:5], wb_adr[1:0], wb_dat, m32};

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    edg_d  = edg_q;
    stat_d = stat_q;
    if (wr) begin
      case (widx)
        A_OUT:   out_d  = (out_q & ~bm) | wd;
        A_SET:   out_d  = out_q | wd;
        A_CLR:   out_d  = out_q & ~wd;
        A_DIR:   dir_d  = (dir_q & ~bm) | wd;
        A_EN:    en_d   = (en_q & ~bm) | wd;
        A_STAT:  stat_d = stat_q & ~wd;
        A_EDGE:  edg_d  = (edg_q & ~bm) | wd;
        default: ;
      endcase
    end
    // A new event outranks a simultaneous clear so no edge is ever lost.
    stat_d = stat_d | ev;
    sync_d[0] = gpi;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = s;
    ack_d  = ~ack_q & wb_cyc & wb_stb;
    irq_d  = |(stat_q & en_q);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      stat_q <= '0;
      edg_q  <= '0;
      sync_q <= '0;
      prev_q <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      edg_q  <= edg_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_n = '0;
    case (widx)
      A_OUT, A_SET, A_CLR: rd_n = out_q;
      A_DIR:               rd_n = dir_q;
      A_IN:                rd_n = s;
      A_EN:                rd_n = en_q;
      A_STAT:              rd_n = stat_q;
      A_EDGE:              rd_n = edg_q;
      default:             rd_n = '0;
    endcase
  end

  assign wb_rdt = 32'(rd_n);
  assign wb_ack = ack_q;
  assign gpo    = out_q;
  assign gpoe   = dir_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: read expectations are queued at issue and
// compared when the ack arrives.
module tb_wb_gpio_irq;
  localparam int NGPIO = 16;
  localparam int SYNC_STAGES = 2;

  logic             wb_clk = 1'b0;
  logic             wb_rst, wb_cyc, wb_stb, wb_we, wb_ack, irq;
  logic [3:0]       wb_sel;
  logic [7:0]       wb_adr;
  logic [31:0]      wb_dat, wb_rdt;
  logic [NGPIO-1:0] gpi, gpo, gpoe;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  wb_gpio_irq #(.NGPIO(NGPIO), .SYNC_STAGES(SYNC_STAGES)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_rdt(wb_rdt), .wb_ack(wb_ack),
    .gpi(gpi), .gpo(gpo), .gpoe(gpoe), .irq(irq)
  );

  always #5 wb_clk = ~wb_clk;

  // All tasks start and end on a falling edge.
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %h want %h", nm, got, want);
    else n_pass++;
  endtask

  task automatic wb_read(input logic [7:0] adr, input logic [31:0] exp, input string nm);
    logic got_ack;
    logic [31:0] e;
    got_ack = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr; wb_sel = 4'hF;
    exp_q.push_back(exp);
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge wb_clk);
      if (wb_ack) begin
        e = exp_q.pop_front();
        got_ack = 1'b1;
        n_chk++;
        if (wb_rdt !== e) $display("FAIL %s: got %h want %h", nm, wb_rdt, e);
        else n_pass++;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    if (!got_ack) begin
      n_chk++;
      $display("FAIL %s: no ack", nm);
      e = exp_q.pop_front();
    end
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic got_ack;
    got_ack = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge wb_clk);
      if (wb_ack) got_ack = 1'b1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got_ack) begin
      n_chk++;
      $display("FAIL write_ack adr %h: no ack", adr);
    end
  endtask

  task automatic test_reset();
    wb_rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat = 0;
    gpi = '0;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    for (int w = 0; w < 8; w++) wb_read(8'(w * 4), 32'h0, "reset_reg");
    chk("reset_gpo", 32'(gpo), 32'h0);
    chk("reset_gpoe", 32'(gpoe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
  endtask

  task automatic test_out();
    wb_write(8'h00, 32'h0000F00F, 4'hF);
    wb_write(8'h04, 32'h00000030, 4'hF);
    wb_write(8'h08, 32'h00000003, 4'hF);
    wb_read(8'h00, 32'h0000F03C, "out_setclr");
    wb_write(8'h04, 32'hFFFFFFFF, 4'b0010);
    wb_read(8'h00, 32'h0000FF3C, "out_set_sel");
    wb_read(8'h04, 32'h0000FF3C, "out_set_reads_out");
    wb_read(8'hEB, 32'h0000FF3C, "out_clr_ignored_adr_bits");
    chk("gpo", 32'(gpo), 32'h0000FF3C);
    wb_write(8'h10, 32'h12345678, 4'hF);
    wb_read(8'h10, 32'h0, "in_write_ignored");
  endtask

  task automatic test_dir();
    wb_write(8'h0C, 32'hFFFFFFFF, 4'hF);
    wb_read(8'h0C, 32'h0000FFFF, "dir_trunc");
    chk("gpoe", 32'(gpoe), 32'h0000FFFF);
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 8'h00; wb_sel = 4'hF;
    exp_q.push_back(32'h0000FF3C);
    exp_q.push_back(32'h0000FF3C);
    repeat (4) begin
      @(negedge wb_clk);
      if (wb_ack) begin
        acks++;
        if (exp_q.size() > 0) chk("b2b_rdt", wb_rdt, exp_q.pop_front());
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    exp_q.delete();
    chk("b2b_ack_count", 32'(acks), 32'd2);
  endtask

  task automatic test_in();
    gpi = 16'hA5A5;
    repeat (3) @(negedge wb_clk);
    wb_read(8'h10, 32'h0000A5A5, "in_read");
    gpi = '0;
    repeat (4) @(negedge wb_clk);
    wb_read(8'h18, 32'h0000A5A5, "stat_fall_default");
    wb_write(8'h18, 32'hFFFFFFFF, 4'hF);
    wb_read(8'h18, 32'h0, "stat_w1c_all");
    chk("irq_disabled", 32'(irq), 32'h0);
  endtask

  task automatic test_rise_irq();
    wb_write(8'h1C, 32'h1, 4'hF);
    wb_write(8'h14, 32'h1, 4'hF);
    gpi[0] = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    @(negedge wb_clk);
    chk("irq_not_early", 32'(irq), 32'h0);
    @(negedge wb_clk);
    chk("irq_k3", 32'(irq), 32'h1);
    wb_read(8'h18, 32'h1, "stat_rise");
    wb_write(8'h18, 32'h1, 4'hF);
    chk("irq_hold_commit", 32'(irq), 32'h1);
    @(negedge wb_clk);
    chk("irq_drop", 32'(irq), 32'h0);
    gpi[0] = 1'b0;
    repeat (5) @(negedge wb_clk);
    wb_read(8'h18, 32'h0, "stat_fall_ignored");
  endtask

  task automatic test_set_wins();
    gpi[3] = 1'b1;
    repeat (4) @(negedge wb_clk);
    wb_read(8'h18, 32'h0, "stat_rise_in_fall_mode");
    gpi[3] = 1'b0;
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_write(8'h18, 32'h8, 4'hF);
    wb_read(8'h18, 32'h8, "stat_set_wins");
    wb_write(8'h18, 32'h8, 4'b1110);
    wb_read(8'h18, 32'h8, "stat_w1c_sel_masked");
  endtask

  task automatic test_reset_mid();
    wb_write(8'h14, 32'h8, 4'hF);
    repeat (2) @(negedge wb_clk);
    chk("irq_pre_reset", 32'(irq), 32'h1);
    wb_rst = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 8'h00; wb_dat = 32'hFFFF; wb_sel = 4'hF;
    @(negedge wb_clk);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ack", 32'(wb_ack), 32'h0);
    wb_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge wb_clk);
    for (int w = 0; w < 8; w++) wb_read(8'(w * 4), 32'h0, "rst_reg");
    chk("rst_gpo", 32'(gpo), 32'h0);
    chk("rst_gpoe", 32'(gpoe), 32'h0);
  endtask

  initial begin
    @(negedge wb_clk);
    test_reset();
    test_out();
    test_dir();
    test_back_to_back();
    test_in();
    test_rise_irq();
    test_set_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
